// File: rtl/d8m_pkg.sv
// rtl/d8m_pkg.sv - shared types and constants for the D8M synthetic pixel source
package d8m_pkg;

  localparam logic [1:0] MODE_FLAT    = 2'd0;
  localparam logic [1:0] MODE_RAMP    = 2'd1;
  localparam logic [1:0] MODE_BARS    = 2'd2;
  localparam logic [1:0] MODE_CHECKER = 2'd3;

  localparam logic [9:0] FULL_SCALE = 10'h3FF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_V_LEAD,
    ST_ACTIVE,
    ST_H_GAP,
    ST_V_GAP
  } d8m_state_e;

  typedef enum logic [1:0] {
    SITE_R,
    SITE_G,
    SITE_B
  } d8m_site_e;

  // Everything captured at frame start and held until the next frame.
  typedef struct packed {
    logic [1:0] mode;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       parity;
  } d8m_frame_cfg_t;

  // GRBG mosaic: even rows G/R, odd rows B/G.
  function automatic d8m_site_e bayer_site(input logic x0, input logic y0);
    if (!y0) return x0 ? SITE_R : SITE_G;
    return x0 ? SITE_G : SITE_B;
  endfunction

endpackage

// File: rtl/d8m_pattern_pixel.sv
// rtl/d8m_pattern_pixel.sv - registered 10-bit Bayer sample for the current x/y and frame settings
module d8m_pattern_pixel
  import d8m_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [15:0]    x,
  input  logic [15:0]    y,
  input  logic [2:0]     bar,
  input  d8m_frame_cfg_t cfg,
  output logic [9:0]     d
);

  d8m_site_e  site;
  logic [7:0] level;
  logic       bar_bit;
  logic [9:0] sample;

  always_comb begin
    site    = bayer_site(x[0], y[0]);
    level   = cfg.g;
    bar_bit = bar[1];
    case (site)
      SITE_R: begin
        level   = cfg.r;
        bar_bit = bar[2];
      end
      SITE_B: begin
        level   = cfg.b;
        bar_bit = bar[0];
      end
      default: ;
    endcase

    case (cfg.mode)
      MODE_FLAT: sample = {level, 2'b00};
      MODE_RAMP: sample = x[9:0];
      MODE_BARS: sample = bar_bit ? FULL_SCALE : 10'h000;
      default:   sample = (x[5] ^ y[5] ^ cfg.parity) ? FULL_SCALE : 10'h000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d <= '0;
    else        d <= en ? sample : 10'h000;
  end

endmodule

// File: rtl/d8m_pattern_gen.sv
// rtl/d8m_pattern_gen.sv - synthetic D8M raw Bayer source with camera-style HS/VS framing
module d8m_pattern_gen
  import d8m_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned H_BLANK  = 160,
  parameter int unsigned V_LEAD   = 16,
  parameter int unsigned V_BLANK  = 4000
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iEN,
  input  logic [1:0]  iMODE,
  input  logic [7:0]  iR,
  input  logic [7:0]  iG,
  input  logic [7:0]  iB,
  output logic        oPIXEL_HS,
  output logic        oPIXEL_VS,
  output logic [9:0]  oPIXEL_D,
  output logic [15:0] oFRAME_CNT,
  output logic        oBUSY
);

  localparam int unsigned BAR_W     = H_ACTIVE / 8;
  localparam logic [15:0] X_LAST    = 16'(H_ACTIVE - 1);
  localparam logic [15:0] Y_LAST    = 16'(V_ACTIVE - 1);
  localparam logic [15:0] BAR_LAST  = 16'(BAR_W - 1);
  localparam logic [31:0] LEAD_LAST = 32'(V_LEAD - 1);
  localparam logic [31:0] HGAP_LAST = 32'(H_BLANK - 1);
  localparam logic [31:0] VGAP_LAST = 32'(V_BLANK - 1);

  d8m_state_e     state;
  logic [15:0]    x;
  logic [15:0]    y;
  logic [15:0]    bar_pos;
  logic [2:0]     bar;
  logic [31:0]    cnt;
  logic [15:0]    frames;
  d8m_frame_cfg_t cfg;
  d8m_frame_cfg_t cfg_in;

  // frames already counts the frame just closed, so parity alternates per frame.
  assign cfg_in = {iMODE, iR, iG, iB, frames[0]};

  // State and counters lead the pins by one edge; HS/VS/BUSY and the pixel
  // register all follow the state, which keeps the sample aligned with HS.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state      <= ST_IDLE;
      x          <= '0;
      y          <= '0;
      bar_pos    <= '0;
      bar        <= '0;
      cnt        <= '0;
      frames     <= '0;
      cfg        <= '0;
      oPIXEL_HS  <= 1'b0;
      oPIXEL_VS  <= 1'b0;
      oBUSY      <= 1'b0;
      oFRAME_CNT <= '0;
    end else begin
      oPIXEL_HS  <= (state == ST_ACTIVE);
      oPIXEL_VS  <= state inside {ST_V_LEAD, ST_ACTIVE, ST_H_GAP};
      oBUSY      <= (state != ST_IDLE);
      oFRAME_CNT <= frames;

      case (state)
        ST_IDLE: begin
          if (iEN) begin
            state <= ST_V_LEAD;
            cnt   <= '0;
            cfg   <= cfg_in;
          end
        end
        ST_V_LEAD: begin
          if (cnt == LEAD_LAST) begin
            state <= ST_ACTIVE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_ACTIVE: begin
          if (x == X_LAST) begin
            state   <= ST_H_GAP;
            x       <= '0;
            bar_pos <= '0;
            bar     <= '0;
          end else begin
            x <= x + 16'd1;
            if (bar_pos == BAR_LAST) begin
              bar_pos <= '0;
              bar     <= bar + 3'd1;
            end else begin
              bar_pos <= bar_pos + 16'd1;
            end
          end
        end
        ST_H_GAP: begin
          if (cnt == HGAP_LAST) begin
            cnt <= '0;
            if (y == Y_LAST) begin
              state  <= ST_V_GAP;
              y      <= '0;
              frames <= frames + 16'd1;
            end else begin
              state <= ST_ACTIVE;
              y     <= y + 16'd1;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_V_GAP: begin
          if (cnt == VGAP_LAST) begin
            cnt <= '0;
            if (iEN) begin
              state <= ST_V_LEAD;
              cfg   <= cfg_in;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  d8m_pattern_pixel u_pixel (
    .clk   (iCLK),
    .rst_n (iRST_N),
    .en    (state == ST_ACTIVE),
    .x     (x),
    .y     (y),
    .bar   (bar),
    .cfg   (cfg),
    .d     (oPIXEL_D)
  );

endmodule
